// File: rtl/rom_region_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_region_loader
// Purpose  : Captures one address window of the ioctl download stream into an
//            on-chip byte ROM. Each 16-bit ioctl word becomes two byte writes
//            while ioctl_wait throttles the HPS. A registered CPU read port,
//            a loaded flag, a byte count and an additive checksum are
//            provided to the game core.
// Revision : 1.0 - initial release
// ============================================================================
module rom_region_loader #(
    parameter int unsigned ADDR_W = 14,
    parameter logic [26:0] BASE   = 27'h29000,
    parameter logic [26:0] SIZE   = 27'h4000,
    parameter logic [7:0]  FILL   = 8'hFF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [7:0]        cpu_dout,
    input  logic              ioctl_download,
    input  logic [26:0]       ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    input  logic              ioctl_wr,
    output logic              ioctl_wait,
    output logic              loaded,
    output logic [ADDR_W:0]   byte_count,
    output logic [15:0]       checksum,
    output logic              overrun
);

    // Byte sequencer states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR_LO = 2'd1;
    localparam logic [1:0] S_WR_HI = 2'd2;

    localparam int unsigned     c_depth     = 2 ** ADDR_W;
    // Window bounds held in 28 bits so BASE+SIZE can never wrap
    localparam logic [27:0]     c_win_lo    = {1'b0, BASE};
    localparam logic [27:0]     c_win_hi    = {1'b0, BASE} + {1'b0, SIZE};
    localparam logic [ADDR_W:0] c_size      = SIZE[ADDR_W:0];
    localparam logic [ADDR_W:0] c_one       = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_one_a   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] c_count_max = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        r_state;
    logic [15:0]       r_word;
    logic [ADDR_W-1:0] r_off;
    logic              r_dl_q;
    logic              r_end_pend;
    logic              r_loaded;
    logic [ADDR_W:0]   r_count;
    logic [15:0]       r_sum;
    logic              r_overrun;
    logic [7:0]        r_dout;
    logic [7:0]        r_rom [0:c_depth-1];

    logic              w_hit;
    logic [ADDR_W-1:0] w_offset;
    logic              w_idle;
    logic              w_rise;
    logic              w_fall;
    logic              w_end_eval;
    logic              w_lo_last;
    logic [ADDR_W-1:0] w_off_hi;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [7:0]        w_wdata;
    logic [ADDR_W:0]   w_cnt_base;
    logic [15:0]       w_sum_base;
    logic [ADDR_W:0]   w_cnt_next;
    logic [15:0]       w_sum_next;

    // Offset only needs the low address bits; the subtraction is exact modulo 2**ADDR_W
    assign w_offset = ioctl_addr[ADDR_W-1:0] - BASE[ADDR_W-1:0];
    assign w_hit    = ioctl_download
                    && ({1'b0, ioctl_addr} >= c_win_lo)
                    && ({1'b0, ioctl_addr} <  c_win_hi);

    assign w_idle   = (r_state == S_IDLE);
    assign w_rise   = ioctl_download & ~r_dl_q;
    assign w_fall   = ~ioctl_download & r_dl_q;

    // The loaded decision waits until any in-flight word has finished
    assign w_end_eval = (w_fall | r_end_pend) & w_idle & ~ioctl_download;

    // The high byte of the last word is dropped when it falls past the window
    assign w_lo_last = (({1'b0, r_off} + c_one) >= c_size);
    assign w_off_hi  = r_off + c_one_a;

    // Reset suppresses the write so an abandoned sequence leaves the ROM untouched
    assign w_we    = reset_n & ((r_state == S_WR_LO) | (r_state == S_WR_HI));
    assign w_waddr = (r_state == S_WR_HI) ? w_off_hi : r_off;
    assign w_wdata = (r_state == S_WR_HI) ? r_word[15:8] : r_word[7:0];

    // A new download restarts the statistics from zero in the same cycle
    assign w_cnt_base = w_rise ? '0 : r_count;
    assign w_sum_base = w_rise ? '0 : r_sum;

    // Saturating byte counter and wrapping checksum
    always_comb begin
        w_cnt_next = w_cnt_base;
        w_sum_next = w_sum_base;
        if (w_we) begin
            if (w_cnt_base != c_count_max) begin
                w_cnt_next = w_cnt_base + c_one;
            end
            w_sum_next = w_sum_base + {8'h00, w_wdata};
        end
    end

    // Byte sequencer: latch a hit word, then emit low and high byte writes
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_word  <= '0;
            r_off   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ioctl_wr && w_hit) begin
                        r_word  <= ioctl_dout;
                        r_off   <= w_offset;
                        r_state <= S_WR_LO;
                    end
                end
                S_WR_LO: begin
                    r_state <= w_lo_last ? S_IDLE : S_WR_HI;
                end
                S_WR_HI: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Download edge tracking, statistics, overrun and loaded flag
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_dl_q     <= 1'b0;
            r_end_pend <= 1'b0;
            r_loaded   <= 1'b0;
            r_count    <= '0;
            r_sum      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_dl_q  <= ioctl_download;
            r_count <= w_cnt_next;
            r_sum   <= w_sum_next;
            if (w_rise) begin
                r_overrun <= 1'b0;
            end
            if (ioctl_wr && !w_idle) begin
                r_overrun <= 1'b1;
            end
            if (w_end_eval) begin
                r_end_pend <= 1'b0;
                if (r_count != '0) begin
                    r_loaded <= 1'b1;
                end
            end else if (w_fall) begin
                r_end_pend <= 1'b1;
            end
        end
    end

    // ROM write port; contents deliberately survive reset
    always_ff @(posedge clk_sys) begin
        if (w_we) begin
            r_rom[w_waddr] <= w_wdata;
        end
    end

    // Registered CPU read; FILL until loaded or when outside the window
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_dout <= '0;
        end else if (r_loaded && ({1'b0, cpu_addr} < c_size)) begin
            r_dout <= r_rom[cpu_addr];
        end else begin
            r_dout <= FILL;
        end
    end

    assign ioctl_wait = (r_state == S_WR_LO) || (r_state == S_WR_HI);
    assign cpu_dout   = r_dout;
    assign loaded     = r_loaded;
    assign byte_count = r_count;
    assign checksum   = r_sum;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_rom_region_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_region_loader
// Purpose  : Directed and randomized bench for rom_region_loader with a
//            byte-level reference model of the window, count and checksum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_region_loader;

    localparam int unsigned ADDR_W = 14;
    localparam logic [26:0] BASE   = 27'h29000;
    localparam logic [26:0] SIZE   = 27'h4000;
    localparam logic [26:0] SIZE2  = 27'h3FFF;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic              ioctl_download = 1'b0;
    logic [26:0]       ioctl_addr = '0;
    logic [15:0]       ioctl_dout = '0;
    logic              ioctl_wr = 1'b0;

    logic [7:0]        cpu_dout;
    logic              ioctl_wait;
    logic              loaded;
    logic [ADDR_W:0]   byte_count;
    logic [15:0]       checksum;
    logic              overrun;

    logic [7:0]        d2_cpu_dout;
    logic              d2_wait;
    logic              d2_loaded;
    logic [ADDR_W:0]   d2_byte_count;
    logic [15:0]       d2_checksum;
    logic              d2_overrun;

    int total = 0;
    int bad   = 0;

    // Reference model: byte image of the full window plus per-instance statistics
    logic [7:0]  m_rom [0:16383];
    int unsigned m_cnt, m_sum, m_cnt2, m_sum2;
    logic        m_loaded;

    rom_region_loader #(.ADDR_W(ADDR_W), .BASE(BASE), .SIZE(SIZE), .FILL(8'hFF)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .ioctl_wait(ioctl_wait), .loaded(loaded),
        .byte_count(byte_count), .checksum(checksum), .overrun(overrun)
    );

    rom_region_loader #(.ADDR_W(ADDR_W), .BASE(BASE), .SIZE(SIZE2), .FILL(8'hFF)) dut2 (
        .clk_sys(clk_sys), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_dout(d2_cpu_dout),
        .ioctl_download(ioctl_download), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .ioctl_wait(d2_wait), .loaded(d2_loaded),
        .byte_count(d2_byte_count), .checksum(d2_checksum), .overrun(d2_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one ioctl word to the model: each byte lands only if inside the window
    task automatic model_word(input logic [26:0] a, input logic [15:0] d);
        logic [26:0] ab;
        logic [7:0]  bv;
        for (int b = 0; b < 2; b++) begin
            ab = a + 27'(b);
            bv = (b == 0) ? d[7:0] : d[15:8];
            if (ab >= BASE && ab < BASE + SIZE) begin
                m_rom[int'(ab - BASE)] = bv;
                if (m_cnt < 16384) m_cnt++;
                m_sum = (m_sum + bv) & 32'hFFFF;
            end
            if (ab >= BASE && ab < BASE + SIZE2) begin
                if (m_cnt2 < 16384) m_cnt2++;
                m_sum2 = (m_sum2 + bv) & 32'hFFFF;
            end
        end
    endtask

    // Issue one word strobe and measure how many cycles ioctl_wait stays high
    task automatic send(input logic [26:0] a, input logic [15:0] d, input int exp_wait);
        int n;
        @(negedge clk_sys);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        n = 0;
        while (ioctl_wait && n < 8) begin
            @(negedge clk_sys);
            n++;
        end
        chk("wait_idle", 32'(ioctl_wait), 32'd0);
        chk("wait_cycles", 32'(n), 32'(exp_wait));
        if (ioctl_download) model_word(a, d);
    endtask

    task automatic rd_chk(input string tag, input logic [ADDR_W-1:0] a);
        logic [7:0] e;
        e = m_loaded ? m_rom[int'(a)] : 8'hFF;
        @(negedge clk_sys);
        cpu_addr = a;
        @(posedge clk_sys);
        #1;
        chk(tag, 32'(cpu_dout), 32'(e));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dout"},  32'(cpu_dout),   32'd0);
        chk({tag, "_wait"},  32'(ioctl_wait), 32'd0);
        chk({tag, "_loaded"},32'(loaded),     32'd0);
        chk({tag, "_count"}, 32'(byte_count), 32'd0);
        chk({tag, "_sum"},   32'(checksum),   32'd0);
        chk({tag, "_ovr"},   32'(overrun),    32'd0);
        chk({tag, "_d2"},    32'({d2_cpu_dout, d2_wait, d2_loaded, d2_byte_count, d2_checksum, d2_overrun}), 32'd0);
    endtask

    task automatic end_download();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        logic [15:0] w1, w2, wr_word;
        int unsigned gold;
        int n;

        m_cnt = 0; m_sum = 0; m_cnt2 = 0; m_sum2 = 0; m_loaded = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk_reset_state("reset0");
        reset_n = 1'b1;

        // Fill value before any download
        for (int i = 0; i < 6; i++) rd_chk("fill_pre", ADDR_W'($urandom));

        // First download: single word, window edges, overrun
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        send(27'h29000, 16'hBEEF, 2);
        chk("single_count", 32'(byte_count), 32'd2);
        chk("single_sum",   32'(checksum),   32'h01AD);

        send(27'h28FFE, 16'($urandom), 0);
        send(27'h2D000, 16'($urandom), 0);
        chk("below_above_count", 32'(byte_count), 32'd2);

        send(27'h2CFFE, 16'h1234, 2);
        chk("edge_count",    32'(byte_count),    32'(m_cnt));
        chk("edge_d2_count", 32'(d2_byte_count), 32'd3);
        chk("edge_d2_sum",   32'(d2_checksum),   32'(m_sum2));

        // Back-to-back strobes: the second word must be dropped
        w1 = 16'($urandom);
        w2 = 16'($urandom);
        @(negedge clk_sys);
        ioctl_addr = 27'h29010; ioctl_dout = w1; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_addr = 27'h29020; ioctl_dout = w2; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        n = 0;
        while (ioctl_wait && n < 8) begin
            @(negedge clk_sys);
            n++;
        end
        chk("ovr_idle", 32'(ioctl_wait), 32'd0);
        model_word(27'h29010, w1);
        chk("ovr_flag",  32'(overrun),    32'd1);
        chk("ovr_count", 32'(byte_count), 32'(m_cnt));
        chk("ovr_sum",   32'(checksum),   32'(m_sum));

        end_download();
        m_loaded = 1'b1;
        chk("dl1_loaded",   32'(loaded),     32'd1);
        chk("dl1_ovr_hold", 32'(overrun),    32'd1);
        chk("dl1_count",    32'(byte_count), 32'(m_cnt));
        rd_chk("rd_0000", 14'h0000);
        rd_chk("rd_0001", 14'h0001);
        rd_chk("rd_3ffe", 14'h3FFE);
        rd_chk("rd_3fff", 14'h3FFF);
        rd_chk("rd_0010", 14'h0010);
        rd_chk("rd_0011", 14'h0011);

        // Full window download
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        chk("dl2_ovr_clear", 32'(overrun),    32'd0);
        chk("dl2_cnt_clear", 32'(byte_count), 32'd0);
        chk("dl2_sum_clear", 32'(checksum),   32'd0);
        chk("dl2_loaded",    32'(loaded),     32'd1);
        m_cnt = 0; m_sum = 0; m_cnt2 = 0; m_sum2 = 0;
        for (int w = 0; w < 8192; w++) send(BASE + 27'(2 * w), 16'($urandom), 2);
        end_download();
        gold = 0;
        for (int i = 0; i < 16384; i++) gold = gold + m_rom[i];
        chk("full_count",    32'(byte_count),    32'd16384);
        chk("full_sum",      32'(checksum),      gold & 32'hFFFF);
        chk("full_d2_count", 32'(d2_byte_count), 32'd16383);
        chk("full_d2_sum",   32'(d2_checksum),   (gold - m_rom[16383]) & 32'hFFFF);
        chk("full_loaded",   32'(loaded),        32'd1);
        for (int i = 0; i < 40; i++) rd_chk("rd_rand", ADDR_W'($urandom));

        // Read latency: the new address must not show before the next edge
        rd_chk("lat_a", 14'h0100);
        @(negedge clk_sys);
        cpu_addr = 14'h0200;
        #1;
        chk("lat_hold", 32'(cpu_dout), 32'(m_rom[256]));
        @(posedge clk_sys);
        #1;
        chk("lat_new", 32'(cpu_dout), 32'(m_rom[512]));

        // Reset in the middle of a word sequence
        wr_word = {~m_rom[257], ~m_rom[256]};
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        ioctl_addr = 27'h29100; ioctl_dout = wr_word; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        chk("midseq_wait", 32'(ioctl_wait), 32'd1);
        reset_n = 1'b0;
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk_reset_state("reset_mid");
        reset_n = 1'b1;
        m_loaded = 1'b0;
        m_cnt = 0; m_sum = 0; m_cnt2 = 0; m_sum2 = 0;

        // Empty download leaves loaded clear
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        send(27'h28000, 16'($urandom), 0);
        send(27'h40000, 16'($urandom), 0);
        end_download();
        chk("empty_loaded", 32'(loaded),     32'd0);
        chk("empty_count",  32'(byte_count), 32'd0);
        rd_chk("empty_fill", 14'h0101);

        // Reload one word; the abandoned high byte must still hold its old value
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        send(27'h29200, 16'($urandom), 2);
        end_download();
        m_loaded = 1'b1;
        chk("dl4_loaded", 32'(loaded),     32'd1);
        chk("dl4_count",  32'(byte_count), 32'd2);
        chk("dl4_sum",    32'(checksum),   32'(m_sum));
        rd_chk("abandon_hi", 14'h0101);
        rd_chk("dl4_lo",     14'h0200);
        rd_chk("dl4_hi",     14'h0201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_region_loader.md
Name: rom_region_loader

Overview:
- Parametrised successor to the fixed-window CPU ROM loaders.
- Captures one address window of the MiSTer ioctl download stream into an on-chip 8-bit ROM.
- Splits each 16-bit ioctl word into two sequential byte writes, throttling the HPS with ioctl_wait.
- Exposes a registered CPU read port, a loaded flag, a byte count and a 16-bit additive checksum for the game core.

Parameters:
- ADDR_W, 14, ROM address width in bytes.
- BASE, 27'h29000, first ioctl byte address of the window. Must be even.
- SIZE, 27'h4000, window length in bytes. Must satisfy SIZE <= 2**ADDR_W.
- FILL, 8'hFF, value returned on cpu_dout while loaded=0.

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_dout  out  8  ROM data; one-cycle registered latency.
- ioctl_download  in  1  download active.
- ioctl_addr  in  27  byte address of the current word; always even.
- ioctl_dout  in  16  word data; [7:0] at ioctl_addr, [15:8] at ioctl_addr+1.
- ioctl_wr  in  1  single-cycle word strobe.
- ioctl_wait  out  1  high while the byte sequencer is busy.
- loaded  out  1  window has been downloaded at least once.
- byte_count  out  ADDR_W+1  bytes written in the current or last download.
- checksum  out  16  mod-2^16 sum of bytes written in the current or last download.
- overrun  out  1  sticky flag: ioctl_wr arrived while busy.

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE.
  - cpu_dout=0, ioctl_wait=0, loaded=0, byte_count=0, checksum=0, overrun=0.
  - ROM contents are not cleared.
  - Reset mid-sequence abandons any pending byte.
- Window hit: ioctl_download && BASE <= ioctl_addr < BASE+SIZE. Compare in 27 bits; offset = ioctl_addr - BASE, truncated to ADDR_W.
- Download start (rising edge of ioctl_download, detected with a registered copy): clear byte_count, checksum and overrun. loaded holds its value.
- Download end (falling edge): loaded <= 1 if byte_count != 0, otherwise unchanged.
- FSM:
  - IDLE:
    - ioctl_wr && hit: latch word and offset, go WR_LO.
    - ioctl_wr && !hit: ignore.
  - WR_LO:
    - Write word[7:0] at offset; byte_count += 1; checksum += word[7:0].
    - If offset+1 < SIZE go WR_HI, else go IDLE. The high byte is dropped at the window end.
  - WR_HI:
    - Write word[15:8] at offset+1; byte_count += 1; checksum += word[15:8].
    - Go IDLE.
- ioctl_wait is a combinational decode: 1 in WR_LO and WR_HI, 0 in IDLE. A hit word therefore holds wait for 2 cycles, starting the cycle after ioctl_wr.
- ioctl_wr while state != IDLE: word ignored, overrun <= 1.
- Download falling while busy: the sequence completes, and the loaded decision uses the count after completion (evaluate on the first IDLE cycle with download low).
- CPU read:
  - cpu_dout <= loaded ? rom[cpu_addr] : FILL, registered.
  - cpu_addr >= SIZE returns FILL.
  - The read port is independent of the write port. Reads during download return FILL only if loaded=0; otherwise they return current contents, possibly mixed old and new.
- byte_count saturates at 2**ADDR_W. checksum wraps mod 2^16.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-WR_LO -> all outputs 0, state IDLE, and the pending high byte is never written.
- Single word: download=1; wr at addr 27'h29000 with dout 16'hBEEF -> wait high 2 cycles; rom[0]=EF, rom[1]=BE; byte_count=2; checksum=16'h01AD.
- Window edges:
  - wr at 27'h28FFE -> ignored.
  - wr at 27'h2CFFE with 16'h1234 -> rom[3FFE]=34, rom[3FFF]=12.
  - With SIZE=27'h3FFF, the same word writes only rom[3FFE]; byte_count +1.
- Overrun: second wr one cycle after the first -> second word dropped, overrun=1; it clears on the next download rising edge.
- Loaded/fill: before any download cpu_dout=FF for all addresses. Full 16 KiB download then download=0 -> loaded=1, byte_count=16384, checksum matches the golden sum, and reads return data one cycle after cpu_addr.
- Empty download: download pulse with no window hits -> loaded unchanged (0), byte_count=0.
